// File: rtl/q3_pkg.sv
// Shared types and sizes for the 4-input truth-table sweep controller.
package q3_pkg;

  localparam int unsigned VEC_COUNT = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned SETTLE_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0]     err_count;
    logic [IDX_W-1:0]     first_fail_idx;
    logic                 fail_valid;
    logic [VEC_COUNT-1:0] f_tt;
    logic [VEC_COUNT-1:0] g_tt;
  } sweep_result_t;

endpackage

// File: rtl/q3_settle_timer.sv
// Settle down-counter: loaded when a vector is applied, flags the last settle cycle.
module q3_settle_timer
  import q3_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expired
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  // A count of one means this is the final settle cycle.
  assign expired = (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/q3_sweep_ctrl.sv
// Walks all 16 input vectors of a 4-input function, captures f/g truth tables
// and compares them against expected tables.
module q3_sweep_ctrl
  import q3_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [VEC_COUNT-1:0] exp_f,
  input  logic [VEC_COUNT-1:0] exp_g,
  input  logic                 f_in,
  input  logic                 g_in,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic                 fail_valid,
  output logic [VEC_COUNT-1:0] f_tt,
  output logic [VEC_COUNT-1:0] g_tt
);

  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(VEC_COUNT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    vec_q, vec_d;
  sweep_result_t       res_q, res_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                load_c;
  logic                expired;
  logic                mismatch_c;

  q3_settle_timer u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_c),
    .value   (SETTLE_VAL),
    .expired (expired)
  );

  assign mismatch_c = (f_in != exp_f[idx_q]) || (g_in != exp_g[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next state and next register values; abort beats everything while busy.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    res_d   = res_q;
    load_c  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = '0;
          res_d   = '0;
        end
      end
      APPLY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          vec_d   = idx_q;
          load_c  = 1'b1;
          state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_d.f_tt[idx_q] = f_in;
          res_d.g_tt[idx_q] = g_in;
          if (mismatch_c) begin
            res_d.err_count = res_q.err_count + CNT_W'(1);
            if (!res_q.fail_valid) begin
              res_d.first_fail_idx = idx_q;
              res_d.fail_valid     = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = APPLY;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == APPLY) || (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = done_d && (res_d.err_count == '0);
  end

  assign {a, b, c, d}    = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = res_q.err_count;
  assign first_fail_idx  = res_q.first_fail_idx;
  assign fail_valid      = res_q.fail_valid;
  assign f_tt            = res_q.f_tt;
  assign g_tt            = res_q.g_tt;

endmodule

// File: tb/tb_q3_sweep_ctrl.sv
// Bench for q3_sweep_ctrl: three instances (settle 2, 0, 3) driving f=a^b^c^d, g=a&b;
// instance 0 results are checked through an expectation queue.
module tb_q3_sweep_ctrl;

  typedef struct packed {
    logic [4:0]  err;
    logic [3:0]  ffi;
    logic        fv;
    logic        ps;
    logic [15:0] ftt;
    logic [15:0] gtt;
  } res_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_f = 16'h6996;
  logic [15:0] exp_g = 16'hF000;

  logic        va [3], vb [3], vc [3], vd [3];
  logic        fin [3], gin [3];
  logic        busy [3], done [3], pass [3], fval [3];
  logic [4:0]  err [3];
  logic [3:0]  ffi [3];
  logic [15:0] ftt [3], gtt [3];

  int   checks = 0;
  int   passes = 0;
  res_t sbq[$];
  logic done_q = 1'b0;
  int   done_t [3];
  int   vec_err [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign fin[k] = va[k] ^ vb[k] ^ vc[k] ^ vd[k];
    assign gin[k] = va[k] & vb[k];
    q3_sweep_ctrl #(.SETTLE_CYCLES((k == 0) ? 2 : ((k == 1) ? 0 : 3))) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .exp_f          (exp_f),
      .exp_g          (exp_g),
      .f_in           (fin[k]),
      .g_in           (gin[k]),
      .a              (va[k]),
      .b              (vb[k]),
      .c              (vc[k]),
      .d              (vd[k]),
      .busy           (busy[k]),
      .done           (done[k]),
      .pass           (pass[k]),
      .err_count      (err[k]),
      .first_fail_idx (ffi[k]),
      .fail_valid     (fval[k]),
      .f_tt           (ftt[k]),
      .g_tt           (gtt[k])
    );
  end

  function automatic logic [3:0] vec(input int k);
    return {va[k], vb[k], vc[k], vd[k]};
  endfunction

  function automatic int settle_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic res_t mk_res(input logic [4:0] e, input logic [3:0] f, input logic v,
                                  input logic p, input logic [15:0] ft, input logic [15:0] gt);
    mk_res = {e, f, v, p, ft, gt};
  endfunction

  // Pop one expectation each time instance 0 enters DONE.
  always @(negedge clk) begin
    res_t got, want;
    if (!rst_n) begin
      done_q = 1'b0;
    end else begin
      if (done[0] && !done_q) begin
        got = {err[0], ffi[0], fval[0], pass[0], ftt[0], gtt[0]};
        checks++;
        if (sbq.size() == 0) begin
          $display("FAIL sb_done: done rose with no queued expectation");
        end else begin
          want = sbq.pop_front();
          if (got !== want)
            $display("FAIL sb_result: got err=%0d ffi=%0d fv=%b pass=%b f_tt=%h g_tt=%h, need err=%0d ffi=%0d fv=%b pass=%b f_tt=%h g_tt=%h",
                     got.err, got.ffi, got.fv, got.ps, got.ftt, got.gtt,
                     want.err, want.ffi, want.fv, want.ps, want.ftt, want.gtt);
          else
            passes++;
        end
      end
      done_q = done[0];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse;
    int n = 0;
    while ((busy[1] || busy[2]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records done cycle and vector-sequence errors; cycle 0 is the start edge.
  task automatic track_sweep(input bit all_duts);
    int n = 0;
    bit fin_all;
    for (int k = 0; k < 3; k++) begin
      done_t[k]  = -1;
      vec_err[k] = 0;
    end
    do begin
      @(negedge clk);
      n++;
      for (int k = 0; k < 3; k++) begin
        if (done_t[k] < 0) begin
          if (done[k]) done_t[k] = n;
          if (n <= 16 * (settle_of(k) + 2) && vec(k) !== 4'((n - 1) / (settle_of(k) + 2)))
            vec_err[k]++;
        end
      end
      fin_all = all_duts ? (done_t[0] >= 0 && done_t[1] >= 0 && done_t[2] >= 0)
                         : (done_t[0] >= 0);
    end while (!fin_all && n < 200);
  endtask

  task automatic wait_vec(input logic [3:0] v, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (vec(0) == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy[0], done[0], pass[0], err[0], ffi[0], fval[0], ftt[0], gtt[0]} !== '0)
      $display("FAIL reset_outputs: got %h, need 0",
               {busy[0], done[0], pass[0], err[0], ffi[0], fval[0], ftt[0], gtt[0]});
    else passes++;
    checks++;
    if (vec(0) !== 4'h0) $display("FAIL reset_vector: got %h, need 0", vec(0));
    else passes++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy[0], done[0]);
    else passes++;
  endtask

  task automatic test_pass_sweep;
    exp_f = 16'h6996;
    exp_g = 16'hF000;
    sbq.push_back(mk_res(5'd0, 4'd0, 1'b0, 1'b1, 16'h6996, 16'hF000));
    start_pulse();
    track_sweep(1'b0);
    checks++;
    if (done_t[0] !== 64) $display("FAIL pass_sweep_len: got %0d cycles, need 64", done_t[0]);
    else passes++;
    checks++;
    if (vec_err[0] !== 0) $display("FAIL pass_sweep_vectors: got %0d bad cycles, need 0", vec_err[0]);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1 || busy[0] !== 1'b0 || ftt[0] !== 16'h6996)
      $display("FAIL done_hold: got done=%b pass=%b busy=%b f_tt=%h, need 1 1 0 6996",
               done[0], pass[0], busy[0], ftt[0]);
    else passes++;
  endtask

  task automatic test_mismatch;
    exp_f = 16'h6996 ^ 16'h0220;
    sbq.push_back(mk_res(5'd2, 4'd5, 1'b1, 1'b0, 16'h6996, 16'hF000));
    start_pulse();
    track_sweep(1'b0);
    checks++;
    if (done_t[0] !== 64) $display("FAIL mismatch_len: got %0d cycles, need 64", done_t[0]);
    else passes++;
    exp_f = 16'h6996;
  endtask

  task automatic test_settle_variants;
    int exp_len [3] = '{64, 32, 80};
    sbq.push_back(mk_res(5'd0, 4'd0, 1'b0, 1'b1, 16'h6996, 16'hF000));
    start_pulse();
    track_sweep(1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (done_t[k] !== exp_len[k])
        $display("FAIL settle_len_%0d: got %0d cycles, need %0d", k, done_t[k], exp_len[k]);
      else passes++;
      checks++;
      if (vec_err[k] !== 0)
        $display("FAIL settle_vectors_%0d: got %0d bad cycles, need 0", k, vec_err[k]);
      else passes++;
    end
    checks++;
    if (pass[1] !== 1'b1 || pass[2] !== 1'b1 || gtt[1] !== 16'hF000 || ftt[2] !== 16'h6996)
      $display("FAIL settle_results: got pass1=%b pass2=%b g_tt1=%h f_tt2=%h, need 1 1 f000 6996",
               pass[1], pass[2], gtt[1], ftt[2]);
    else passes++;
  endtask

  task automatic test_abort;
    bit ok;
    start_pulse();
    wait_vec(4'd7, ok);
    checks++;
    if (!ok) $display("FAIL abort_reach_vec7: got timeout, need vector 7");
    else passes++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy[0] !== 1'b0) $display("FAIL abort_idle: got busy=%b, need 0", busy[0]);
    else passes++;
    checks++;
    if (done[0] !== 1'b0 || pass[0] !== 1'b0)
      $display("FAIL abort_no_done: got done=%b pass=%b, need 0 0", done[0], pass[0]);
    else passes++;
    checks++;
    if (ftt[0] !== 16'h0016 || gtt[0] !== 16'h0000 || err[0] !== 5'd0)
      $display("FAIL abort_partial: got f_tt=%h g_tt=%h err=%0d, need 0016 0000 0",
               ftt[0], gtt[0], err[0]);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (vec(0) !== 4'd7) $display("FAIL abort_vec_hold: got %0d, need 7", vec(0));
    else passes++;
    sbq.push_back(mk_res(5'd0, 4'd0, 1'b0, 1'b1, 16'h6996, 16'hF000));
    start_pulse();
    track_sweep(1'b0);
    checks++;
    if (done_t[0] !== 64 || vec_err[0] !== 0)
      $display("FAIL abort_restart: got %0d cycles %0d bad vectors, need 64 0", done_t[0], vec_err[0]);
    else passes++;
  endtask

  task automatic test_start_busy;
    int c = 0;
    sbq.push_back(mk_res(5'd0, 4'd0, 1'b0, 1'b1, 16'h6996, 16'hF000));
    start_pulse();
    repeat (20) begin
      @(negedge clk);
      c++;
    end
    start = 1'b1;
    @(negedge clk);
    c++;
    start = 1'b0;
    while (!done[0] && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c !== 64) $display("FAIL start_busy_len: got %0d cycles, need 64", c);
    else passes++;
  endtask

  task automatic test_start_abort_prio;
    int n = 0;
    while ((busy[1] || busy[2]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy[0] !== 1'b1 || done[0] !== 1'b0)
      $display("FAIL prio_start_wins: got busy=%b done=%b, need 1 0", busy[0], done[0]);
    else passes++;
    checks++;
    if (ftt[0] !== 16'h0000 || err[0] !== 5'd0 || fval[0] !== 1'b0)
      $display("FAIL prio_start_clears: got f_tt=%h err=%0d fv=%b, need 0000 0 0",
               ftt[0], err[0], fval[0]);
    else passes++;
    repeat (3) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0)
      $display("FAIL prio_abort_wins: got busy=%b done=%b pass=%b, need 0 0 0",
               busy[0], done[0], pass[0]);
    else passes++;
  endtask

  task automatic test_exp_change;
    bit ok;
    int n = 0;
    sbq.push_back(mk_res(5'd1, 4'd12, 1'b1, 1'b0, 16'h6996, 16'hF000));
    start_pulse();
    wait_vec(4'd9, ok);
    checks++;
    if (!ok) $display("FAIL exp_change_reach: got timeout, need vector 9");
    else passes++;
    exp_f = 16'h6996 ^ 16'h1008;
    while (!done[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done[0]) $display("FAIL exp_change_done: got done=0 after %0d cycles, need 1", n);
    else passes++;
    @(negedge clk);
    exp_f = 16'h6996;
  endtask

  task automatic test_reset_mid;
    bit ok;
    start_pulse();
    wait_vec(4'd10, ok);
    checks++;
    if (!ok) $display("FAIL reset_mid_reach: got timeout, need vector 10");
    else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec(0), busy[0], done[0], pass[0], err[0], ffi[0], fval[0], ftt[0], gtt[0]} !== '0)
      $display("FAIL reset_mid_clear: got %h, need 0",
               {vec(0), busy[0], done[0], pass[0], err[0], ffi[0], fval[0], ftt[0], gtt[0]});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || vec(0) !== 4'd0)
      $display("FAIL reset_mid_idle: got busy=%b done=%b vec=%0d, need 0 0 0",
               busy[0], done[0], vec(0));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_pass_sweep();
    test_mismatch();
    test_settle_variants();
    test_abort();
    test_start_busy();
    test_start_abort_prio();
    test_exp_change();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() !== 0) $display("FAIL sb_drained: got %0d pending, need 0", sbq.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
